// File: rtl/test.sv
// test: half adder with registered result and saturating carry-event counter
module test #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             sum,
    output logic             carry,
    output logic             sum_q,
    output logic             carry_q,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             cnt_sat
);
    assign sum     = a ^ b;
    assign carry   = a & b;
    assign cnt_sat = &carry_cnt;

    // Register the adder result and count edges sampled with carry set, clear first, sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= 1'b0;
            carry_q   <= 1'b0;
            carry_cnt <= '0;
        end else begin
            sum_q     <= sum;
            carry_q   <= carry;
            if (cnt_clr)
                carry_cnt <= '0;
            else if (carry && !cnt_sat)
                carry_cnt <= carry_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_test.sv
// tb_test: directed-vector bench for the half adder, its registers and counters of width 8 and 2
module tb_test;
    logic       clk = 1'b0, run = 1'b0;
    logic       rst, a, b, cnt_clr;
    logic       sum, carry, sum_q, carry_q, cnt_sat;
    logic [7:0] carry_cnt;
    logic       sum2, carry2, sum_q2, carry_q2, cnt_sat2;
    logic [1:0] carry_cnt2;
    int         vectors = 0, miscompares = 0;

    test #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sum(sum), .carry(carry),
        .sum_q(sum_q), .carry_q(carry_q), .cnt_clr(cnt_clr),
        .carry_cnt(carry_cnt), .cnt_sat(cnt_sat)
    );

    test #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .sum(sum2), .carry(carry2),
        .sum_q(sum_q2), .carry_q(carry_q2), .cnt_clr(cnt_clr),
        .carry_cnt(carry_cnt2), .cnt_sat(cnt_sat2)
    );

    // Clock only toggles while run is set, so the first phase sees an idle clock
    always #5 clk = run ? ~clk : clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] pat [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] exp_cs [4] = '{2'b00, 2'b01, 2'b10, 2'b01};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; cnt_clr = 1'b0;
        #10;
        chk("rst_sum_q", sum_q, 0);
        chk("rst_carry_q", carry_q, 0);
        chk("rst_cnt", carry_cnt, 0);
        chk("rst_sat", cnt_sat, 0);
        rst = 1'b0;
        // combinational path with the clock idle
        for (int i = 0; i < 4; i++) begin
            {a, b} = pat[i];
            #100;
            chk("comb_mid", {carry, sum}, exp_cs[i]);
            #100;
            chk("comb_end", {carry, sum}, exp_cs[i]);
        end
        chk("idle_sum_q", sum_q, 0);
        chk("idle_cnt", carry_cnt, 0);
        // three carry edges, then a=1 b=0
        run = 1'b1;
        @(negedge clk); a = 1'b1; b = 1'b1;
        edge1();
        chk("c1_cnt", carry_cnt, 1);
        chk("c1_q", {carry_q, sum_q}, 2'b10);
        edge1(); edge1();
        chk("c3_cnt", carry_cnt, 3);
        @(negedge clk); b = 1'b0;
        #1;
        chk("c3_comb", {carry, sum}, 2'b01);
        chk("c3_hold_q", {carry_q, sum_q}, 2'b10);
        edge1();
        chk("c4_q", {carry_q, sum_q}, 2'b01);
        chk("c4_cnt", carry_cnt, 3);
        // reach 5 then reset mid-cycle
        @(negedge clk); b = 1'b1;
        edge1(); edge1();
        chk("pre_rst_cnt", carry_cnt, 5);
        chk("pre_rst_cnt2", carry_cnt2, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt", carry_cnt, 0);
        chk("arst_q", {carry_q, sum_q}, 2'b00);
        chk("arst_cnt2", carry_cnt2, 0);
        chk("arst_sat2", cnt_sat2, 0);
        edge1();
        chk("rst_hold_cnt", carry_cnt, 0);
        chk("rst_hold_q", carry_q, 0);
        @(negedge clk); rst = 1'b0;
        // saturation of the 2-bit counter over six carry edges
        for (int i = 1; i <= 6; i++) begin
            edge1();
            chk("sat_cnt2", carry_cnt2, (i > 3) ? 3 : i);
            chk("sat_flag2", cnt_sat2, (i >= 3) ? 1 : 0);
        end
        chk("sat_cnt8", carry_cnt, 6);
        chk("sat_flag8", cnt_sat, 0);
        // clear wins over increment
        @(negedge clk); cnt_clr = 1'b1;
        edge1();
        chk("clr_cnt", carry_cnt, 0);
        chk("clr_cnt2", carry_cnt2, 0);
        chk("clr_sat2", cnt_sat2, 0);
        @(negedge clk); cnt_clr = 1'b0;
        edge1();
        chk("after_clr_cnt", carry_cnt, 1);
        chk("after_clr_cnt2", carry_cnt2, 1);
        // input toggles between edges
        #2 a = 1'b0; b = 1'b1;
        #1;
        chk("tog1_comb", {carry, sum}, 2'b01);
        chk("tog1_q", {carry_q, sum_q}, 2'b10);
        a = 1'b1; b = 1'b1;
        #1;
        chk("tog2_comb", {carry, sum}, 2'b10);
        a = 1'b0; b = 1'b0;
        #1;
        chk("tog3_comb", {carry, sum}, 2'b00);
        chk("tog3_q", {carry_q, sum_q}, 2'b10);
        @(negedge clk); a = 1'b1; b = 1'b0;
        edge1();
        chk("tog4_q", {carry_q, sum_q}, 2'b01);
        chk("tog4_cnt", carry_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
